// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: shift-register scoreboard of in-flight writes driving
// operand forwarding selects, load-use stall and a saturating stall counter.
module hazard_scoreboard #(
  parameter int NUM_STAGES     = 3,
  parameter int LOAD_STAGE     = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SEL_WIDTH      = $clog2(NUM_STAGES+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic                           id_reg_write,
  input  logic                           id_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0]      id_rd,
  input  logic [REG_ADDR_WIDTH-1:0]      id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]      id_rs2,
  input  logic                           id_uses_rs1,
  input  logic                           id_uses_rs2,
  input  logic                           flush,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data,
  input  logic [DATA_WIDTH-1:0]          rf_rs1,
  input  logic [DATA_WIDTH-1:0]          rf_rs2,
  output logic                           stall,
  output logic [SEL_WIDTH-1:0]           fwd_sel_rs1,
  output logic [SEL_WIDTH-1:0]           fwd_sel_rs2,
  output logic [DATA_WIDTH-1:0]          op_rs1,
  output logic [DATA_WIDTH-1:0]          op_rs2,
  output logic [15:0]                    stall_count
);

  logic [NUM_STAGES-1:0]     valid_q, valid_d, load_q, load_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q [NUM_STAGES];
  logic [REG_ADDR_WIDTH-1:0] rd_d [NUM_STAGES];
  logic [15:0]               cnt_q, cnt_d;

  logic [REG_ADDR_WIDTH-1:0] src_rs  [2];
  logic [DATA_WIDTH-1:0]     src_rf  [2];
  logic [1:0]                src_use;
  logic [SEL_WIDTH-1:0]      sel     [2];
  logic [DATA_WIDTH-1:0]     op      [2];
  logic [1:0]                hz;
  logic [1:0]                found;
  logic                      capture;

  assign src_rs[0] = id_rs1;
  assign src_rs[1] = id_rs2;
  assign src_rf[0] = rf_rs1;
  assign src_rf[1] = rf_rs2;
  assign src_use   = {id_uses_rs2, id_uses_rs1};

  // Scan youngest first; the first hit decides, older entries for the same rd are shadowed.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      sel[s]   = '0;
      op[s]    = src_rf[s];
      hz[s]    = 1'b0;
      found[s] = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (!found[s] && src_use[s] && (src_rs[s] != '0) && valid_q[k] &&
            (rd_q[k] == src_rs[s])) begin
          found[s] = 1'b1;
          if (!load_q[k] || (k >= LOAD_STAGE)) begin
            sel[s] = SEL_WIDTH'(k + 1);
            op[s]  = stage_data[k*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            hz[s] = 1'b1;
          end
        end
      end
    end
  end

  assign stall       = id_valid & (hz[0] | hz[1]);
  assign fwd_sel_rs1 = sel[0];
  assign fwd_sel_rs2 = sel[1];
  assign op_rs1      = op[0];
  assign op_rs2      = op[1];
  assign stall_count = cnt_q;

  assign capture = id_valid & id_reg_write & (id_rd != '0) & ~stall & ~flush;

  always_comb begin
    valid_d  = {valid_q[NUM_STAGES-2:0], capture};
    load_d   = {load_q[NUM_STAGES-2:0], capture & id_mem_read};
    rd_d[0]  = capture ? id_rd : '0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      rd_d[k] = rd_q[k-1];
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        rd_q[k] <= rd_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic,
// all checked against an age-ordered history model of in-flight writes.
module tb_hazard_scoreboard;
  localparam int NS = 3;
  localparam int LS = 1;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = $clog2(NS+1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, id_reg_write = 0, id_mem_read = 0, flush = 0;
  logic [AW-1:0] id_rd = 0, id_rs1 = 0, id_rs2 = 0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0;
  logic [NS*DW-1:0] stage_data = '0;
  logic [DW-1:0] rf_rs1 = 0, rf_rs2 = 0;
  logic stall;
  logic [SW-1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic [DW-1:0] op_rs1, op_rs2;
  logic [15:0] stall_count;

  hazard_scoreboard #(.NUM_STAGES(NS), .LOAD_STAGE(LS), .DATA_WIDTH(DW),
                      .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .flush(flush),
    .stage_data(stage_data), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .stall(stall),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2), .op_rs1(op_rs1),
    .op_rs2(op_rs2), .stall_count(stall_count));

  always #5 clk = ~clk;

  typedef struct {bit v; bit [AW-1:0] rd; bit ld;} ent_t;
  ent_t pipe[$];           // index = age in stages after decode (0 = EX)
  logic [DW-1:0] sd [NS];
  bit fix_sd = 0;
  int unsigned m_cnt = 0;
  bit e_stall;
  int e_sel1, e_sel2;
  logic [DW-1:0] e_op1, e_op2;
  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void resolve(input bit [AW-1:0] rs, input bit uses, input logic [DW-1:0] rfv,
                                  output int sel, output logic [DW-1:0] op, output bit hz);
    sel = 0; op = rfv; hz = 0;
    if (!uses || rs == 0) return;
    for (int i = 0; i < pipe.size(); i++) begin
      if (pipe[i].v && pipe[i].rd == rs) begin
        if (!pipe[i].ld || i >= LS) begin sel = i + 1; op = sd[i]; end
        else hz = 1;
        return;
      end
    end
  endfunction

  function automatic void eval();
    bit h1, h2;
    resolve(id_rs1, id_uses_rs1, rf_rs1, e_sel1, e_op1, h1);
    resolve(id_rs2, id_uses_rs2, rf_rs2, e_sel2, e_op2, h2);
    e_stall = id_valid && (h1 || h2);
  endfunction

  task automatic model_clear();
    pipe.delete();
    for (int i = 0; i < NS; i++) pipe.push_back('{v: 0, rd: 0, ld: 0});
    m_cnt = 0;
  endtask

  task automatic apply(input bit v, rw, mr, input bit [AW-1:0] rd, r1, r2,
                       input bit u1, u2, fl);
    @(negedge clk);
    id_valid = v; id_reg_write = rw; id_mem_read = mr; id_rd = rd;
    id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2; flush = fl;
    if (!fix_sd) for (int k = 0; k < NS; k++) sd[k] = $urandom;
    for (int k = 0; k < NS; k++) stage_data[k*DW +: DW] = sd[k];
    rf_rs1 = $urandom; rf_rs2 = $urandom;
    #1;
    eval();
    check_eq("stall", 32'(stall), 32'(e_stall));
    check_eq("sel1", 32'(fwd_sel_rs1), 32'(e_sel1));
    check_eq("sel2", 32'(fwd_sel_rs2), 32'(e_sel2));
    check_eq("op1", op_rs1, e_op1);
    check_eq("op2", op_rs2, e_op2);
    check_eq("count", 32'(stall_count), m_cnt);
  endtask

  task automatic tick();
    bit cap;
    cap = id_valid && id_reg_write && id_rd != 0 && !e_stall && !flush;
    @(posedge clk);
    pipe.push_front('{v: cap, rd: cap ? id_rd : '0, ld: cap && id_mem_read});
    void'(pipe.pop_back());
    if (e_stall && m_cnt != 16'hFFFF) m_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin apply(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
  endtask

  initial begin
    model_clear();
    #12 rst = 1'b0;
    // Reset state
    apply(1, 0, 0, 0, 3, 4, 1, 1, 0);
    check_eq("rst_op1_rf", op_rs1, rf_rs1);
    tick();

    // Back-to-back ALU dependency
    apply(1, 1, 0, 10, 10, 5, 1, 1, 0); tick();
    fix_sd = 1; sd[0] = 32'h10; sd[1] = 32'h22; sd[2] = 32'h33;
    apply(1, 1, 0, 11, 10, 10, 1, 1, 0);
    check_eq("b2b_stall", 32'(stall), 0);
    check_eq("b2b_sel1", 32'(fwd_sel_rs1), 1);
    check_eq("b2b_sel2", 32'(fwd_sel_rs2), 1);
    check_eq("b2b_op1", op_rs1, 32'h10);
    check_eq("b2b_op2", op_rs2, 32'h10);
    tick();
    apply(1, 0, 0, 0, 10, 10, 1, 1, 0);
    check_eq("b2b_age_sel", 32'(fwd_sel_rs1), 2);
    check_eq("b2b_age_op", op_rs1, 32'h22);
    tick();
    fix_sd = 0;
    idle(3);

    // Load-use
    apply(1, 1, 1, 11, 0, 0, 0, 0, 0); tick();
    apply(1, 1, 0, 12, 11, 0, 1, 1, 0);
    check_eq("lu_stall", 32'(stall), 1);
    check_eq("lu_sel_rf", 32'(fwd_sel_rs1), 0);
    tick();
    apply(1, 1, 0, 12, 11, 0, 1, 1, 0);
    check_eq("lu_stall_after", 32'(stall), 0);
    check_eq("lu_count", 32'(stall_count), 1);
    check_eq("lu_sel", 32'(fwd_sel_rs1), 2);
    check_eq("lu_op", op_rs1, sd[1]);
    tick();
    idle(3);

    // Youngest wins
    apply(1, 1, 0, 7, 0, 0, 0, 0, 0); tick();
    apply(1, 1, 0, 9, 0, 0, 0, 0, 0); tick();
    apply(1, 1, 0, 7, 0, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 7, 7, 1, 1, 0);
    check_eq("yw_sel", 32'(fwd_sel_rs1), 1);
    check_eq("yw_op", op_rs2, sd[0]);
    tick();
    idle(3);

    // x0 and unused operands
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 0, 1, 1, 0);
    check_eq("x0_sel", 32'(fwd_sel_rs1), 0);
    check_eq("x0_stall", 32'(stall), 0);
    tick();
    apply(1, 1, 1, 4, 0, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 4, 0, 0, 0);
    check_eq("unused_sel", 32'(fwd_sel_rs2), 0);
    check_eq("unused_stall", 32'(stall), 0);
    tick();
    idle(3);

    // Flush, flush-with-stall, drain
    apply(1, 1, 0, 6, 0, 0, 0, 0, 1); tick();
    apply(1, 0, 0, 0, 6, 0, 1, 0, 0);
    check_eq("flush_sel", 32'(fwd_sel_rs1), 0);
    tick();
    apply(1, 1, 1, 13, 0, 0, 0, 0, 0); tick();
    apply(1, 1, 0, 15, 13, 0, 1, 0, 1);
    check_eq("fl_stall", 32'(stall), 1);
    tick();
    apply(1, 0, 0, 0, 15, 0, 1, 0, 0);
    check_eq("fl_nocap", 32'(fwd_sel_rs1), 0);
    tick();
    apply(1, 1, 0, 8, 0, 0, 0, 0, 0); tick();
    idle(3);
    apply(1, 0, 0, 0, 8, 8, 1, 1, 0);
    check_eq("drain_op", op_rs1, rf_rs1);
    tick();

    // Reset mid-stall
    apply(1, 1, 1, 14, 0, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 14, 14, 1, 1, 0);
    check_eq("mr_pre_stall", 32'(stall), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("mr_stall", 32'(stall), 0);
    check_eq("mr_count", 32'(stall_count), 0);
    check_eq("mr_sel1", 32'(fwd_sel_rs1), 0);
    check_eq("mr_sel2", 32'(fwd_sel_rs2), 0);
    model_clear();
    eval();
    rst = 1'b0;
    tick();

    // Random traffic over a small register window to provoke frequent hazards
    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
